// File: rtl/word_compare_unit.sv
// word_compare_unit: serial target/guess word comparator producing match qualifiers for the scorer
module word_compare_unit #(
  parameter int CHAR_W   = 8,
  parameter int WORD_LEN = 8
) (
  input  logic                       Clk,
  input  logic                       Reset_n,
  input  logic                       LoadTarget,
  input  logic [CHAR_W*WORD_LEN-1:0] TargetWord,
  input  logic                       Start,
  input  logic [CHAR_W*WORD_LEN-1:0] GuessWord,
  output logic                       Busy,
  output logic                       Done,
  output logic                       FullMatch,
  output logic                       FirstHalf,
  output logic                       SecondHalf,
  output logic                       Flag,
  output logic [7:0]                 AttemptCount
);
  localparam int W  = CHAR_W * WORD_LEN;
  localparam int IW = $clog2(WORD_LEN);
  typedef enum logic {IDLE, COMPARE} state_t;
  state_t state_q, state_d;
  logic [W-1:0] target_q, target_d, guess_q, guess_d;
  logic [IW-1:0] idx_q, idx_d;
  logic miss_first_q, miss_first_d, miss_second_q, miss_second_d;
  logic done_q, done_d, full_q, full_d, first_q, first_d, second_q, second_d, flag_q, flag_d;
  logic [7:0] cnt_q, cnt_d;
  logic mis, lo, last, first_ok, second_ok;
  always_comb begin
    mis           = guess_q[idx_q*CHAR_W +: CHAR_W] != target_q[idx_q*CHAR_W +: CHAR_W];
    lo            = idx_q < IW'(WORD_LEN / 2);
    last          = idx_q == IW'(WORD_LEN - 1);
    first_ok      = !(miss_first_q | (mis & lo));
    second_ok     = !(miss_second_q | (mis & !lo));
    state_d       = state_q;
    target_d      = target_q;
    guess_d       = guess_q;
    idx_d         = idx_q;
    miss_first_d  = miss_first_q;
    miss_second_d = miss_second_q;
    done_d        = 1'b0;
    full_d        = full_q;
    first_d       = first_q;
    second_d      = second_q;
    flag_d        = flag_q;
    cnt_d         = cnt_q;
    // LoadTarget takes priority in both states, aborting any compare in flight
    if (LoadTarget) begin
      state_d  = IDLE;
      target_d = TargetWord;
      cnt_d    = 8'd0;
      full_d   = 1'b0;
      first_d  = 1'b0;
      second_d = 1'b0;
      flag_d   = 1'b0;
    end else if (state_q == IDLE) begin
      if (Start) begin
        state_d       = COMPARE;
        guess_d       = GuessWord;
        idx_d         = '0;
        miss_first_d  = 1'b0;
        miss_second_d = 1'b0;
      end
    end else begin
      miss_first_d  = !first_ok;
      miss_second_d = !second_ok;
      idx_d         = last ? idx_q : idx_q + IW'(1);
      if (last) begin
        state_d  = IDLE;
        done_d   = 1'b1;
        first_d  = first_ok;
        second_d = second_ok;
        full_d   = first_ok & second_ok;
        flag_d   = cnt_q == 8'd0;
        cnt_d    = cnt_q + {7'd0, cnt_q != 8'hff};
      end
    end
  end
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q       <= IDLE;
      target_q      <= '0;
      guess_q       <= '0;
      idx_q         <= '0;
      miss_first_q  <= 1'b0;
      miss_second_q <= 1'b0;
      done_q        <= 1'b0;
      full_q        <= 1'b0;
      first_q       <= 1'b0;
      second_q      <= 1'b0;
      flag_q        <= 1'b0;
      cnt_q         <= 8'd0;
    end else begin
      state_q       <= state_d;
      target_q      <= target_d;
      guess_q       <= guess_d;
      idx_q         <= idx_d;
      miss_first_q  <= miss_first_d;
      miss_second_q <= miss_second_d;
      done_q        <= done_d;
      full_q        <= full_d;
      first_q       <= first_d;
      second_q      <= second_d;
      flag_q        <= flag_d;
      cnt_q         <= cnt_d;
    end
  end
  assign Busy         = state_q == COMPARE;
  assign Done         = done_q;
  assign FullMatch    = full_q;
  assign FirstHalf    = first_q;
  assign SecondHalf   = second_q;
  assign Flag         = flag_q;
  assign AttemptCount = cnt_q;
endmodule

// File: tb/tb_word_compare_unit.sv
// tb_word_compare_unit: randomized scoreboard bench for word_compare_unit
module tb_word_compare_unit;
  logic Clk = 1'b0, Reset_n = 1'b1, LoadTarget = 1'b0, Start = 1'b0;
  logic [63:0] TargetWord = '0, GuessWord = '0;
  logic Busy, Done, FullMatch, FirstHalf, SecondHalf, Flag;
  logic [7:0] AttemptCount;
  typedef struct packed {logic full, first, second, flag; logic [7:0] cnt;} res_t;
  res_t exp_q[$];
  logic [63:0] tgt = '0;
  int cnt = 0, total = 0, bad = 0;

  word_compare_unit #(.CHAR_W(8), .WORD_LEN(8)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .LoadTarget(LoadTarget), .TargetWord(TargetWord),
    .Start(Start), .GuessWord(GuessWord), .Busy(Busy), .Done(Done), .FullMatch(FullMatch),
    .FirstHalf(FirstHalf), .SecondHalf(SecondHalf), .Flag(Flag), .AttemptCount(AttemptCount)
  );

  always #5 Clk = ~Clk;

  // Strings literals put the last letter in the low byte; char 0 must be the first letter
  function automatic logic [63:0] w(input logic [63:0] s);
    return {<<8{s}};
  endfunction

  function automatic logic [63:0] mutate(input logic [63:0] t);
    logic [63:0] g = t;
    for (int i = 0; i < 8; i++)
      if ($urandom_range(0, 3) == 0) g[i*8 +: 8] = 8'($urandom);
    return g;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [63:0] g);
    res_t r;
    r.first  = g[31:0] == tgt[31:0];
    r.second = g[63:32] == tgt[63:32];
    r.full   = r.first && r.second;
    r.flag   = cnt == 0;
    cnt      = cnt < 255 ? cnt + 1 : 255;
    r.cnt    = 8'(cnt);
    exp_q.push_back(r);
  endtask

  always @(negedge Clk) begin
    if (Reset_n && Done) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got Done=1 expected no Done");
      end else begin
        res_t e;
        e = exp_q.pop_front();
        chk("result", {FullMatch, FirstHalf, SecondHalf, Flag, AttemptCount}, e);
        chk("busy_in_done", Busy, 0);
      end
    end
  end

  task automatic issue(input logic [63:0] g);
    Start = 1'b1;
    GuessWord = g;
    push_exp(g);
    @(negedge Clk);
    Start = 1'b0;
    GuessWord = {$urandom, $urandom};
  endtask

  task automatic wait_done(input int already);
    int n = already;
    while (!Done && n < 20) begin
      @(negedge Clk);
      n++;
    end
    chk("latency", n, 9);
  endtask

  task automatic load(input logic [63:0] t);
    LoadTarget = 1'b1;
    TargetWord = t;
    tgt = t;
    cnt = 0;
    @(negedge Clk);
    LoadTarget = 1'b0;
    chk("after_load", {Busy, FullMatch, FirstHalf, SecondHalf, Flag, AttemptCount}, 0);
  endtask

  task automatic outs_zero(input string name);
    chk(name, {Busy, Done, FullMatch, FirstHalf, SecondHalf, Flag, AttemptCount}, 0);
  endtask

  initial begin
    #1 Reset_n = 1'b0;
    #1 outs_zero("reset_state");
    @(negedge Clk);
    Reset_n = 1'b1;
    @(negedge Clk);
    load(w("ABCDEFGH"));
    issue(w("ABCDEFGH"));
    wait_done(1);
    issue(w("ABCDXXXX"));
    wait_done(1);
    issue(w("XXXXEFGH"));
    wait_done(1);
    // Start pulse and guess change mid-compare must be ignored
    issue(w("ABCDEFGX"));
    repeat (2) @(negedge Clk);
    Start = 1'b1;
    GuessWord = w("ABCDEFGH");
    @(negedge Clk);
    Start = 1'b0;
    wait_done(4);
    issue(w("ABCDEFGH"));
    wait_done(1);
    // Abort by LoadTarget partway through a compare
    issue(w("ABCDEFGH"));
    repeat (3) @(negedge Clk);
    exp_q.delete();
    load(w("ABCDEFGH"));
    repeat (12) @(negedge Clk);
    issue(w("ABCDEFGH"));
    wait_done(1);
    // Asynchronous reset partway through a compare
    issue(mutate(tgt));
    repeat (3) @(negedge Clk);
    #2 Reset_n = 1'b0;
    #1 outs_zero("async_reset");
    exp_q.delete();
    tgt = '0;
    cnt = 0;
    @(negedge Clk);
    Reset_n = 1'b1;
    repeat (12) @(negedge Clk);
    chk("idle_after_reset", Busy, 0);
    for (int r = 0; r < 3; r++) begin
      load({$urandom, $urandom});
      for (int i = 0; i < 15; i++) begin
        issue(mutate(tgt));
        wait_done(1);
        repeat ($urandom_range(0, 2)) @(negedge Clk);
      end
    end
    load(w("SATURATE"));
    for (int i = 0; i < 258; i++) begin
      issue(mutate(tgt));
      wait_done(1);
    end
    @(negedge Clk);
    chk("saturated", AttemptCount, 255);
    repeat (5) @(negedge Clk);
    chk("pending", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
